quant_reconstructor: RTL and testbench
======================================

# quant_reconstructor

Sequential inverse of the quantization divider chain. Takes an INDEX_W-bit quantized index, the top-stage unit, and the divider residual. It rebuilds the original activation by MSB-first shift-and-add, one bit per cycle. Sits on the dequantization side of the datapath, between quantized storage and downstream consumers. Uses a valid/ready handshake on both ports.

## Interface
- INDEX_W, 8, index width; equals the number of divider stages reconstructed.
- DATA_W, 32, width of unit, residual and activation.

- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input request valid.
- o_ready  output  1  block can accept input; high only in IDLE.
- i_index  input  INDEX_W  quantized index, MSB = first divider stage.
- i_unit  input  DATA_W  unit used by the first divider stage (U_top).
- i_left  input  DATA_W  residual left by the last divider stage.
- o_valid  output  1  o_activation valid; high only in DONE.
- i_ready  input  1  downstream accepts result.
- o_activation  output  DATA_W  reconstructed activation.
- o_busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - o_ready=1.
  - On i_valid & o_ready: capture i_index into the shift register and i_unit into the unit register.
  - Load accumulator with i_left, clear the step counter, go to RUN.
- **RUN**: one stage per cycle, MSB first.
  - If the current index MSB = 1, then acc <= acc + unit_reg.
  - Always unit_reg <= {1'b0, unit_reg[DATA_W-1:1]}, and shift the index left by 1.
  - Counter increments each cycle. After step INDEX_W-1, go to DONE.
- **DONE**
  - o_valid=1, o_activation=acc; both held stable until i_ready.
  - On o_valid & i_ready, go to IDLE.
- **Arithmetic**
  - Stage j weight is floor(U_top / 2^j), taken from the successively shifted unit.
  - The result is not index*U_top>>(INDEX_W-1). Truncation must match the divider chain exactly.
  - Exact-inverse property: given index and left produced by the divider chain from activation A with unit U_top, o_activation == A.
  - Accumulator addition wraps modulo 2^DATA_W with no saturation and no overflow flag.
- Inputs are sampled only at the accept edge. Changes to i_index, i_unit or i_left during RUN or DONE are ignored.
- i_valid while busy: o_ready=0, so no acceptance and no side effect.
- Index 0: all RUN steps add nothing; result = i_left.
- U_top = 0: result = i_left.

## Timing
- **Reset**: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_activation=0, internal acc, unit, index and counter all 0.
- **Reset mid-operation**: the operation is abandoned immediately, with the same values as reset. No result is emitted after reset releases.
- **Latency**: accept on edge t. RUN occupies edges t+1..t+INDEX_W. o_valid rises after edge t+INDEX_W, i.e. INDEX_W cycles after acceptance.
- **Throughput**: the output handshake edge returns to IDLE, and the next accept can occur on the following edge. Minimum period is INDEX_W+2 cycles per result.
- **Output backpressure**: o_valid held indefinitely while i_ready=0. i_ready while not in DONE is ignored.
- o_busy = (state != IDLE); it is high in the cycle after acceptance through the output handshake edge.

## Structure
- Shared package quant_pkg:
  - INDEX_W and DATA_W defaults, shared with the divider.
  - State enum {IDLE, RUN, DONE}.
  - Counter width constant $clog2(INDEX_W).
- Sub-module dequant_stage:
  - Combinational single step taking (acc, unit, bit) and producing (acc', unit>>1).
  - It is the mirror of one divider stage.
  - The top module holds the FSM, registers and handshake.

## Test plan
- Reset check: assert reset_n=0 mid-RUN -> all outputs at reset values, o_ready=1 and no o_valid after release.
- Round-trip: activation 100, U_top=128 gives index 0x64, left 0. Driving index=0x64, unit=128, left=0 -> o_activation=100, o_valid exactly 8 cycles after accept.
- Round-trip with residual: index=0xFF, unit=128, left=745 -> o_activation=1000.
- Truncation: index=0xFF, unit=200, left=0 -> 397 (200+100+50+25+12+6+3+1), not 398.
- Wrap: index=0x80, unit=0xFFFFFFFF, left=1 -> o_activation=0.
- Handshake:
  - Hold i_ready=0 for 5 cycles in DONE -> o_valid and the value stay stable.
  - Toggle the inputs and keep i_valid=1 during RUN -> no second accept.
  - Back-to-back requests -> accept period is 10 cycles.
  - Random index/unit/left checked against the reference model sum.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared constants and types for the quantization divider and its reconstructor.
package quant_pkg;

    localparam int DEF_INDEX_W = 8;
    localparam int DEF_DATA_W  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A 1-stage chain still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_INDEX_W);

endpackage

// File: rtl/quant_reconstructor_if.sv
// Request/response handshake bundle between quantized storage and the reconstructor.
interface quant_reconstructor_if
    import quant_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic               i_valid;
    logic               o_ready;
    logic [INDEX_W-1:0] i_index;
    logic [DATA_W-1:0]  i_unit;
    logic [DATA_W-1:0]  i_left;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_W-1:0]  o_activation;
    logic               o_busy;

    modport master (
        output i_valid, i_index, i_unit, i_left, i_ready,
        input  o_ready, o_valid, o_activation, o_busy
    );

    modport slave (
        input  i_valid, i_index, i_unit, i_left, i_ready,
        output o_ready, o_valid, o_activation, o_busy
    );
endinterface

// File: rtl/quant_reconstructor_dequant_stage.sv
// One reconstruction step: the mirror of a single divider stage.
module dequant_stage #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] unit_in,
    input  logic              idx_bit,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] unit_out
);
    // Wraps modulo 2^DATA_W; the halved unit truncates exactly as the divider did.
    assign acc_out  = idx_bit ? (acc_in + unit_in) : acc_in;
    assign unit_out = {1'b0, unit_in[DATA_W-1:1]};
endmodule

// File: rtl/quant_reconstructor.sv
// Rebuilds an activation from (index, top unit, residual), one divider stage per cycle, MSB first.
module quant_reconstructor
    import quant_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    quant_reconstructor_if.slave bus
);
    localparam int CNT_W = cnt_width(INDEX_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(INDEX_W - 1);

    localparam logic [1:0] IDLE = 2'(S_IDLE);
    localparam logic [1:0] RUN  = 2'(S_RUN);
    localparam logic [1:0] DONE = 2'(S_DONE);

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  unit_q, unit_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  stage_acc;
    logic [DATA_W-1:0]  stage_unit;

    dequant_stage #(.DATA_W(DATA_W)) u_stage (
        .acc_in   (acc_q),
        .unit_in  (unit_q),
        .idx_bit  (index_q[INDEX_W-1]),
        .acc_out  (stage_acc),
        .unit_out (stage_unit)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        unit_d  = unit_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    index_d = bus.i_index;
                    unit_d  = bus.i_unit;
                    acc_d   = bus.i_left;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = stage_acc;
                unit_d  = stage_unit;
                index_d = index_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            unit_q  <= '0;
            index_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            unit_q  <= unit_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator only moves in RUN, so it is stable for the whole DONE phase.
    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_valid      = (state_q == DONE);
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_activation = acc_q;

endmodule

// File: tb/tb_quant_reconstructor.sv
// Scoreboard bench for quant_reconstructor: driver pushes expectations, monitor checks results.
module tb_quant_reconstructor;
    import quant_pkg::*;

    localparam int IW = DEF_INDEX_W;
    localparam int DW = DEF_DATA_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    quant_reconstructor_if #(.INDEX_W(IW), .DATA_W(DW)) bus ();

    quant_reconstructor #(.INDEX_W(IW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int rdy_mode = 0;
    logic [DW-1:0] exp_q[$];
    int lat_q[$];

    // Reference: residual plus floor(U/2^j) for every set index bit j (MSB is j=0).
    function automatic logic [DW-1:0] ref_model(input logic [IW-1:0] idx,
                                                 input logic [DW-1:0] u,
                                                 input logic [DW-1:0] l);
        longint unsigned sum;
        sum = longint'(l);
        for (int j = 0; j < IW; j++) begin
            if (idx[IW-1-j]) sum += longint'(u) / (longint'(1) << j);
        end
        return sum[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // i_ready changes just after the active edge so it is stable for the monitor.
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'($urandom_range(0, 1));
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.o_valid) begin
                    if (!prev_valid) begin
                        if (lat_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL latency: o_valid rose with no accept recorded (cycle %0d)", cycle);
                        end else begin
                            check("latency", 64'(cycle - lat_q.pop_front()), 64'(IW));
                        end
                    end
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL spurious_output: got 0x%0h expected no o_valid", bus.o_activation);
                    end else begin
                        check("activation", 64'(bus.o_activation), 64'(exp_q[0]));
                        if (bus.i_ready) begin
                            $display("[TB] result 0x%0h taken at cycle %0d", bus.o_activation, cycle);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                prev_valid = bus.o_valid && !bus.i_ready;
            end
        end
    end

    // Waiting cycles present random data with i_valid high: none of it may be accepted.
    task automatic send(input logic [IW-1:0] idx, input logic [DW-1:0] u,
                        input logic [DW-1:0] l, input logic [DW-1:0] exp,
                        input bit keep, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!bus.o_ready && n < 200) begin
            bus.i_valid = 1'b1;
            bus.i_index = IW'($urandom);
            bus.i_unit  = $urandom;
            bus.i_left  = $urandom;
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 200 cycles");
            bus.i_valid = 1'b0;
            return;
        end
        bus.i_valid = 1'b1;
        bus.i_index = idx;
        bus.i_unit  = u;
        bus.i_left  = l;
        exp_q.push_back(exp);
        lat_q.push_back(cycle + 1);
        acc_cyc = cycle + 1;
        $display("[TB] accept idx=0x%0h unit=0x%0h left=0x%0h exp=0x%0h at cycle %0d",
                 idx, u, l, exp, acc_cyc);
        @(negedge clk);
        check("busy_after_accept", 64'({bus.o_busy, bus.o_ready}), 64'(2'b10));
        if (keep) begin
            bus.i_index = IW'($urandom);
            bus.i_unit  = $urandom;
            bus.i_left  = $urandom;
        end else begin
            bus.i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_ready"}, 64'(bus.o_ready), 64'(1));
        check({tag, "_o_valid"}, 64'(bus.o_valid), 64'(0));
        check({tag, "_o_busy"}, 64'(bus.o_busy), 64'(0));
        check({tag, "_o_activation"}, 64'(bus.o_activation), 64'(0));
    endtask

    initial begin
        int a, b, w;
        logic [IW-1:0] ridx;
        logic [DW-1:0] ru, rl;
        bus.i_valid = 1'b0;
        bus.i_index = '0;
        bus.i_unit  = '0;
        bus.i_left  = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        rdy_mode = 0;
        send(8'h64, 32'd128, 32'd0, 32'd100, 1'b0, a);
        drain();
        send(8'hFF, 32'd128, 32'd745, 32'd1000, 1'b0, a);
        drain();
        send(8'hFF, 32'd200, 32'd0, 32'd397, 1'b0, a);
        drain();
        send(8'h80, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, a);
        drain();
        send(8'h00, 32'h1234_5678, 32'd77, 32'd77, 1'b0, a);
        drain();
        send(8'hA5, 32'd0, 32'd9, 32'd9, 1'b0, a);
        drain();

        // Back-to-back with i_valid held: second accept exactly INDEX_W+2 cycles later.
        send(8'h3C, 32'd1000, 32'd5, ref_model(8'h3C, 32'd1000, 32'd5), 1'b1, a);
        send(8'hC3, 32'd999, 32'd6, ref_model(8'hC3, 32'd999, 32'd6), 1'b0, b);
        check("accept_period", 64'(b - a), 64'(IW + 2));
        drain();

        // Backpressure: result must sit in DONE while i_ready stays low.
        rdy_mode = 2;
        send(8'h5A, 32'hDEAD_BEEF, 32'd3, ref_model(8'h5A, 32'hDEAD_BEEF, 32'd3), 1'b0, a);
        w = 0;
        while (!bus.o_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (5) begin
            @(negedge clk);
            check("hold_o_valid", 64'(bus.o_valid), 64'(1));
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of RUN abandons the operation with no output afterwards.
        send(8'hFF, 32'd4096, 32'd12345, 32'd0, 1'b0, a);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (14) @(negedge clk);
        check("post_reset_o_ready", 64'(bus.o_ready), 64'(1));
        check("post_reset_o_valid", 64'(bus.o_valid), 64'(0));

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ridx = IW'($urandom);
            case ($urandom_range(0, 7))
                0:       ru = '0;
                1:       ru = '1;
                default: ru = $urandom;
            endcase
            rl = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + DW'($urandom_range(0, 255)) : $urandom;
            send(ridx, ru, rl, ref_model(ridx, ru, rl), 1'($urandom_range(0, 1)), a);
        end
        rdy_mode = 0;
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
